// File: rtl/agex_stage_pkg.sv
// Shared AGEX-stage types: decode and AGEX latch layouts, op_I codes, multiplier FSM encodings.
package agex_stage_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [5:0] {
    INVALID_I = 6'd0,
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, ADDI_I, ANDI_I, ORI_I, XORI_I,
    SLT_I, SLTU_I, SLTI_I, SLTIU_I,
    SLL_I, SRL_I, SRA_I, SLLI_I, SRLI_I, SRAI_I,
    LUI_I, AUIPC_I, JAL_I, JALR_I, LW_I, SW_I, CSRR_I, CSRW_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    MUL_I
  } op_e;

  typedef struct packed {
    logic              valid;
    logic [31:0]       inst;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] pcplus;
    op_e               op_I;
    logic [31:0]       inst_count;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] sxt_imm;
    logic              is_br;
    logic              wr_reg;
    logic [4:0]        rd;
  } de_latch_t;

  typedef struct packed {
    logic              valid;
    logic [31:0]       inst;
    logic [DATA_W-1:0] PC;
    op_e               op_I;
    logic [31:0]       inst_count;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] st_data;
    logic              wr_reg;
    logic [4:0]        rd;
  } agex_latch_t;

  localparam int unsigned DE_latch_WIDTH        = $bits(de_latch_t);
  localparam int unsigned AGEX_latch_WIDTH      = $bits(agex_latch_t);
  localparam int unsigned from_AGEX_to_DE_WIDTH = 2;
  localparam int unsigned from_AGEX_to_FE_WIDTH = 1 + DATA_W;

  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;

endpackage

// File: rtl/agex_stage_if.sv
// Decode-to-AGEX bus: decode latch in, mispredict/busy feedback and AGEX latch out.
interface agex_stage_if;
  import agex_stage_pkg::*;

  de_latch_t                        from_DE_latch;
  logic [from_AGEX_to_DE_WIDTH-1:0] from_AGEX_to_DE;
  logic [from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE;
  agex_latch_t                      AGEX_latch_out;

  modport master (
    output from_DE_latch,
    input  from_AGEX_to_DE,
    input  from_AGEX_to_FE,
    input  AGEX_latch_out
  );

  modport slave (
    input  from_DE_latch,
    output from_AGEX_to_DE,
    output from_AGEX_to_FE,
    output AGEX_latch_out
  );
endinterface

// File: rtl/agex_stage_iter_mul.sv
// iter_mul: shift-add multiplier, one partial product per cycle, low DBITS bits of the product.
module iter_mul
  import agex_stage_pkg::*;
#(
  parameter int unsigned DBITS     = 32,
  parameter int unsigned MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DBITS-1:0] p
);

  localparam int unsigned    CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DBITS-1:0] acc_q, acc_d;
  logic [DBITS-1:0] mcand_q, mcand_d;
  logic [DBITS-1:0] mplier_q, mplier_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = MUL_DONE;
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Busy already in the start cycle so decode holds the MUL from its first cycle on.
  assign busy = ((state_q == MUL_IDLE) && start) || (state_q == MUL_RUN);
  assign done = (state_q == MUL_DONE);
  assign p    = acc_q;

endmodule

// File: rtl/agex_stage.sv
// agex_stage: RV32 execute/address-generation stage with control-flow resolution.
// Define AGEX_ITER_MUL_EN to run MUL on the iterative multiplier with decode back-pressure.
module agex_stage
  import agex_stage_pkg::*;
#(
  parameter int unsigned DBITS     = DATA_W,
  parameter int unsigned MUL_STEPS = 32
) (
  input logic         clk,
  input logic         reset,
  agex_stage_if.slave agex_bus
);

  de_latch_t        de;
  agex_latch_t      agex_d, agex_q;
  logic [DBITS-1:0] rs1, rs2, imm;
  logic [DBITS-1:0] result, mul_p, jalr_sum, br_target, fe_target;
  logic             cond, br_mispred, busy, mul_ready;

  assign de  = agex_bus.from_DE_latch;
  assign rs1 = de.rs1_val;
  assign rs2 = de.rs2_val;
  assign imm = de.sxt_imm;

  always_comb begin
    result = '0;
    case (de.op_I)
      ADD_I:          result = rs1 + rs2;
      ADDI_I:         result = rs1 + imm;
      SUB_I:          result = rs1 - rs2;
      AND_I:          result = rs1 & rs2;
      ANDI_I:         result = rs1 & imm;
      OR_I:           result = rs1 | rs2;
      ORI_I:          result = rs1 | imm;
      XOR_I:          result = rs1 ^ rs2;
      XORI_I:         result = rs1 ^ imm;
      SLT_I:          result = DBITS'($signed(rs1) < $signed(rs2));
      SLTI_I:         result = DBITS'($signed(rs1) < $signed(imm));
      SLTU_I:         result = DBITS'(rs1 < rs2);
      SLTIU_I:        result = DBITS'(rs1 < imm);
      SLL_I:          result = rs1 << rs2[4:0];
      SLLI_I:         result = rs1 << imm[4:0];
      SRL_I:          result = rs1 >> rs2[4:0];
      SRLI_I:         result = rs1 >> imm[4:0];
      SRA_I:          result = $signed(rs1) >>> rs2[4:0];
      SRAI_I:         result = $signed(rs1) >>> imm[4:0];
      LUI_I:          result = imm;
      AUIPC_I:        result = de.PC + imm;
      JAL_I, JALR_I:  result = de.pcplus;
      LW_I, SW_I:     result = rs1 + imm;
      CSRR_I, CSRW_I: result = rs1;
      MUL_I:          result = mul_p;
      default:        result = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (de.op_I)
      BEQ_I:   cond = (rs1 == rs2);
      BNE_I:   cond = (rs1 != rs2);
      BLT_I:   cond = ($signed(rs1) < $signed(rs2));
      BGE_I:   cond = ($signed(rs1) >= $signed(rs2));
      BLTU_I:  cond = (rs1 < rs2);
      BGEU_I:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

  // Fetch always predicts pcplus, so any taken branch or jump is a mispredict.
  assign jalr_sum   = rs1 + imm;
  assign br_target  = (de.op_I == JALR_I) ? {jalr_sum[DBITS-1:1], 1'b0} : de.PC + imm;
  assign br_mispred = de.valid &&
                      ((de.is_br && cond) || (de.op_I == JAL_I) || (de.op_I == JALR_I));
  assign fe_target  = br_mispred ? br_target : {DBITS{1'b0}};

`ifdef AGEX_ITER_MUL_EN
  logic mul_start, mul_done;

  assign mul_start = de.valid && (de.op_I == MUL_I);
  assign mul_ready = (de.op_I != MUL_I) || mul_done;

  iter_mul #(
    .DBITS    (DBITS),
    .MUL_STEPS(MUL_STEPS)
  ) u_iter_mul (
    .clk  (clk),
    .reset(reset),
    .start(mul_start),
    .a    (rs1),
    .b    (rs2),
    .busy (busy),
    .done (mul_done),
    .p    (mul_p)
  );
`else
  logic unused_mul_steps;

  assign unused_mul_steps = ^MUL_STEPS;
  assign mul_p            = rs1 * rs2;
  assign busy             = 1'b0;
  assign mul_ready        = 1'b1;
`endif

  // Invalid input and every busy cycle load an all-zero bubble.
  always_comb begin
    agex_d = '0;
    if (de.valid && !busy && mul_ready) begin
      agex_d.valid      = 1'b1;
      agex_d.inst       = de.inst;
      agex_d.PC         = de.PC;
      agex_d.op_I       = de.op_I;
      agex_d.inst_count = de.inst_count;
      agex_d.result     = result;
      agex_d.st_data    = rs2;
      agex_d.wr_reg     = de.wr_reg;
      agex_d.rd         = de.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) agex_q <= '0;
    else       agex_q <= agex_d;
  end

  assign agex_bus.from_AGEX_to_DE = {br_mispred, busy};
  assign agex_bus.from_AGEX_to_FE = {br_mispred, fe_target};
  assign agex_bus.AGEX_latch_out  = agex_q;

endmodule

// File: tb/tb_agex_stage.sv
// Self-checking bench for agex_stage: vector table plus MUL and reset sequences.
// Follows AGEX_ITER_MUL_EN the same way as the RTL.
module tb_agex_stage;
  import agex_stage_pkg::*;

  localparam int unsigned STEPS = 32;

  typedef struct {
    op_e         op;
    logic        valid;
    logic [31:0] rs1, rs2, imm, pc, pcplus;
    logic        is_br;
    logic [31:0] res;
    logic        mis;
    logic [31:0] tgt;
  } vec_t;

  logic         clk;
  logic         reset;
  int           checks;
  int           failures;
  vec_t         vecs[$];
  agex_latch_t  exp_q[$];

  agex_stage_if bus ();

  agex_stage #(
    .DBITS    (32),
    .MUL_STEPS(STEPS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .agex_bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(op_e op, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm,
                              logic [31:0] res);
    vec_t v;
    v = '{op: op, valid: 1'b1, rs1: rs1, rs2: rs2, imm: imm, pc: 32'h80, pcplus: 32'h84,
          is_br: 1'b0, res: res, mis: 1'b0, tgt: 32'h0};
    return v;
  endfunction

  function automatic vec_t mkcf(op_e op, logic valid, logic [31:0] rs1, logic [31:0] rs2,
                                logic [31:0] imm, logic [31:0] pc, logic [31:0] pcplus,
                                logic is_br, logic [31:0] res, logic mis, logic [31:0] tgt);
    vec_t v;
    v = '{op: op, valid: valid, rs1: rs1, rs2: rs2, imm: imm, pc: pc, pcplus: pcplus,
          is_br: is_br, res: res, mis: mis, tgt: tgt};
    return v;
  endfunction

  function automatic de_latch_t mk_de(vec_t v, int idx);
    de_latch_t d;
    d            = '0;
    d.valid      = v.valid;
    d.inst       = 32'h0001_0013 + 32'(idx);
    d.PC         = v.pc;
    d.pcplus     = v.pcplus;
    d.op_I       = v.op;
    d.inst_count = 32'(idx) + 32'd1;
    d.rs1_val    = v.rs1;
    d.rs2_val    = v.rs2;
    d.sxt_imm    = v.imm;
    d.is_br      = v.is_br;
    d.wr_reg     = ~idx[0];
    d.rd         = 5'(idx + 3);
    return d;
  endfunction

  function automatic agex_latch_t exp_entry(de_latch_t d, logic [31:0] res);
    agex_latch_t e;
    e = '0;
    if (d.valid) begin
      e.valid      = 1'b1;
      e.inst       = d.inst;
      e.PC         = d.PC;
      e.op_I       = d.op_I;
      e.inst_count = d.inst_count;
      e.result     = res;
      e.st_data    = d.rs2_val;
      e.wr_reg     = d.wr_reg;
      e.rd         = d.rd;
    end
    return e;
  endfunction

  function automatic logic is_branch(op_e op);
    return op inside {BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One stage cycle: drive, check feedback mid-cycle, queue the latch expectation, compare after edge.
  task automatic cycle(input de_latch_t d, input agex_latch_t exp, input logic exp_mis,
                       input logic [31:0] exp_tgt, input logic exp_busy, input logic ign_res,
                       input string name);
    agex_latch_t got, want;
    @(negedge clk);
    bus.from_DE_latch = d;
    #1;
    check({name, "_de"}, 256'(bus.from_AGEX_to_DE), 256'({exp_mis, exp_busy}));
    check({name, "_fe_mis"}, 256'(bus.from_AGEX_to_FE[32]), 256'(exp_mis));
    if (exp_mis) check({name, "_tgt"}, 256'(bus.from_AGEX_to_FE[31:0]), 256'(exp_tgt));
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got  = bus.AGEX_latch_out;
    want = exp_q.pop_front();
    if (ign_res) begin
      got.result  = '0;
      want.result = '0;
    end
    check({name, "_latch"}, 256'(got), 256'(want));
  endtask

  task automatic run_mul(input de_latch_t d, input logic [31:0] res, input string name);
`ifdef AGEX_ITER_MUL_EN
    for (int c = 0; c < STEPS + 1; c++) cycle(d, '0, 1'b0, 32'h0, 1'b1, 1'b0, {name, "_busy"});
`endif
    cycle(d, exp_entry(d, res), 1'b0, 32'h0, 1'b0, 1'b0, name);
  endtask

  initial begin
    vec_t      v;
    de_latch_t d, dm, dm2, dadd;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.from_DE_latch = '0;

    vecs.push_back(mk(ADD_I,   32'd5,         32'd7,         32'd0,         32'd12));
    vecs.push_back(mk(SUB_I,   32'd5,         32'd7,         32'd0,         32'hFFFF_FFFE));
    vecs.push_back(mk(ADDI_I,  32'hFFFF_FFFF, 32'd0,         32'd1,         32'h0));
    vecs.push_back(mk(AND_I,   32'hF0F0,      32'hFF00,      32'd0,         32'hF000));
    vecs.push_back(mk(ANDI_I,  32'hF0F0,      32'd0,         32'h0FF0,      32'h00F0));
    vecs.push_back(mk(OR_I,    32'hF0F0,      32'hFF00,      32'd0,         32'hFFF0));
    vecs.push_back(mk(ORI_I,   32'hF0F0,      32'd0,         32'h000F,      32'hF0FF));
    vecs.push_back(mk(XOR_I,   32'hF0F0,      32'hFF00,      32'd0,         32'h0FF0));
    vecs.push_back(mk(XORI_I,  32'hF0F0,      32'd0,         32'hFFFF_FFFF, 32'hFFFF_0F0F));
    vecs.push_back(mk(SLT_I,   32'd1,         32'hFFFF_FFFF, 32'd0,         32'd0));
    vecs.push_back(mk(SLTU_I,  32'd1,         32'hFFFF_FFFF, 32'd0,         32'd1));
    vecs.push_back(mk(SLTI_I,  32'hFFFF_FFFE, 32'd0,         32'd1,         32'd1));
    vecs.push_back(mk(SLTIU_I, 32'hFFFF_FFFE, 32'd0,         32'd1,         32'd0));
    vecs.push_back(mk(SLL_I,   32'd1,         32'h3F,        32'd0,         32'h8000_0000));
    vecs.push_back(mk(SLLI_I,  32'd3,         32'd0,         32'd4,         32'h30));
    vecs.push_back(mk(SRL_I,   32'h8000_0000, 32'h24,        32'd0,         32'h0800_0000));
    vecs.push_back(mk(SRA_I,   32'h8000_0000, 32'h24,        32'd0,         32'hF800_0000));
    vecs.push_back(mk(SRLI_I,  32'hF000_0000, 32'd0,         32'h1C,        32'hF));
    vecs.push_back(mk(SRAI_I,  32'h8000_0000, 32'd0,         32'h1F,        32'hFFFF_FFFF));
    vecs.push_back(mk(LUI_I,   32'd0,         32'd0,         32'h1234_5000, 32'h1234_5000));
    vecs.push_back(mk(AUIPC_I, 32'd0,         32'd0,         32'h1000,      32'h1080));
    vecs.push_back(mk(LW_I,    32'h1000,      32'd0,         32'hFFFF_FFFC, 32'hFFC));
    vecs.push_back(mk(SW_I,    32'h2000,      32'hDEAD,      32'd8,         32'h2008));
    vecs.push_back(mk(CSRR_I,  32'hABCD,      32'd0,         32'd0,         32'hABCD));
    vecs.push_back(mk(CSRW_I,  32'h55,        32'h99,        32'd0,         32'h55));
    vecs.push_back(mk(INVALID_I, 32'd5,       32'd7,         32'd3,         32'd0));
    vecs.push_back(mkcf(BEQ_I,  1'b1, 32'd3, 32'd3, 32'd8, 32'h100, 32'h104, 1'b1,
                        32'd0, 1'b1, 32'h108));
    vecs.push_back(mkcf(BNE_I,  1'b1, 32'd3, 32'd3, 32'd8, 32'h100, 32'h104, 1'b1,
                        32'd0, 1'b0, 32'h0));
    vecs.push_back(mkcf(BLT_I,  1'b1, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 32'h204, 1'b1,
                        32'd0, 1'b1, 32'h210));
    vecs.push_back(mkcf(BLTU_I, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 32'h204, 1'b1,
                        32'd0, 1'b0, 32'h0));
    vecs.push_back(mkcf(BGE_I,  1'b1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h200, 32'h204,
                        1'b1, 32'd0, 1'b1, 32'h1F0));
    vecs.push_back(mkcf(BGEU_I, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h200, 32'h204,
                        1'b1, 32'd0, 1'b0, 32'h0));
    vecs.push_back(mkcf(JAL_I,  1'b1, 32'd0, 32'd0, 32'h20, 32'h200, 32'h204, 1'b0,
                        32'h204, 1'b1, 32'h220));
    vecs.push_back(mkcf(JALR_I, 1'b1, 32'h203, 32'd0, 32'd4, 32'h110, 32'h114, 1'b0,
                        32'h114, 1'b1, 32'h206));
    vecs.push_back(mkcf(BEQ_I,  1'b0, 32'd3, 32'd3, 32'd8, 32'h100, 32'h104, 1'b1,
                        32'd0, 1'b0, 32'h0));
    vecs.push_back(mkcf(JAL_I,  1'b0, 32'd0, 32'd0, 32'h20, 32'h200, 32'h204, 1'b0,
                        32'h204, 1'b0, 32'h0));

    // Outputs during and right after reset with an all-zero input latch.
    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", 256'(bus.AGEX_latch_out), 256'(0));
    check("rst_de", 256'(bus.from_AGEX_to_DE), 256'(0));
    check("rst_fe", 256'(bus.from_AGEX_to_FE), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_latch", 256'(bus.AGEX_latch_out), 256'(0));
    check("post_rst_de", 256'(bus.from_AGEX_to_DE), 256'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      d = mk_de(v, i);
      cycle(d, exp_entry(d, v.res), v.mis, v.tgt, 1'b0, is_branch(v.op),
            $sformatf("v%0d_%s", i, v.op.name()));
    end

    dm   = mk_de(mk(MUL_I, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0), 100);
    dm2  = mk_de(mk(MUL_I, 32'h1234_5678, 32'd9, 32'd0, 32'd0), 101);
    dadd = mk_de(mk(ADD_I, 32'd40, 32'd2, 32'd0, 32'd0), 102);

    run_mul(dm, 32'hFFFF_FFFD, "mul1");
    cycle(dadd, exp_entry(dadd, 32'd42), 1'b0, 32'h0, 1'b0, 1'b0, "add_after_mul");

`ifdef AGEX_ITER_MUL_EN
    // Leaves the multiplier in RUN with cnt=10.
    for (int c = 0; c < 11; c++) cycle(dm2, '0, 1'b0, 32'h0, 1'b1, 1'b0, "mul_pre_rst");
`else
    cycle(dadd, exp_entry(dadd, 32'd42), 1'b0, 32'h0, 1'b0, 1'b0, "add_pre_rst");
`endif
    @(negedge clk);
    reset = 1'b1;
    bus.from_DE_latch = '0;
    @(posedge clk);
    #1;
    check("midrst_latch", 256'(bus.AGEX_latch_out), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_de", 256'(bus.from_AGEX_to_DE), 256'(0));
    check("midrst_fe", 256'(bus.from_AGEX_to_FE), 256'(0));

    run_mul(dm2, 32'hA3D7_0A38, "mul2");
    cycle(dadd, exp_entry(dadd, 32'd42), 1'b0, 32'h0, 1'b0, 1'b0, "add_after_mul2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
